// File: rtl/hdlc_tx_framer_if.sv
// -----------------------------------------------------------------------------
// hdlc_tx_framer_if
// Byte-in / bit-out bundle for the HDLC transmit framer.
//   in_data[7:0] : frame byte, sent LSB first
//   in_last      : marks in_data as the final byte of the frame
//   in_valid     : byte offered by the source
//   in_ready     : framer holding register empty (accept on valid && ready)
//   out          : serial line bit, one per clock
//   busy         : frame (flags, payload, abort) in progress on the line
//   underrun     : one-cycle pulse on the first abort bit
// Modports: master = byte source / line observer, slave = framer.
// -----------------------------------------------------------------------------
interface hdlc_tx_framer_if;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic       busy;
  logic       underrun;

  modport master (
    output in_data, in_last, in_valid,
    input  in_ready, out, busy, underrun
  );

  modport slave (
    input  in_data, in_last, in_valid,
    output in_ready, out, busy, underrun
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
// -----------------------------------------------------------------------------
// hdlc_tx_framer
// Transmit-side HDLC framer: wraps frame bytes in 01111110 flags, sends them
// LSB first one bit per clock, inserts a 0 after five consecutive payload 1s,
// and sends eight 1s (abort) if the source runs dry mid-frame.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : hdlc_tx_framer_if.slave (byte handshake in, serial line out)
// Build option:
//   HDLC_TX_FLAG_IDLE_EN defined   -> idle line carries continuous flags,
//                                     frames start only on a flag boundary
//   HDLC_TX_FLAG_IDLE_EN undefined -> idle line held at 1 (mark idle)
// -----------------------------------------------------------------------------
module hdlc_tx_framer (
  input  logic             clk,
  input  logic             reset,
  hdlc_tx_framer_if.slave  bus
);

  // Flag 01111110 is symmetric, so bit i of this constant is the i-th bit on
  // the line.
  localparam logic [7:0] FLAG     = 8'h7E;
  localparam logic [2:0] ONES_MAX = 3'd5;

`ifdef HDLC_TX_FLAG_IDLE_EN
  localparam bit FLAG_IDLE = 1'b1;
`else
  localparam bit FLAG_IDLE = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_OPEN, S_DATA, S_STUFF, S_CLOSE, S_ABORT
  } state_t;

  // state_q/idx_q describe the bit currently on the line, except in IDLE where
  // idx_q is the next fill-flag bit (0 means "at a flag boundary").
  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  logic       out_q, out_d;
  logic [7:0] hold_q;
  logic       hold_last_q;
  logic       hold_full_q;

  logic       load_byte;   // move holding byte into the shifter, free holding reg
  logic       advance;     // step past the current payload bit (no stuff pending)
  logic [2:0] idx_inc;
  logic       accept;

  assign idx_inc = idx_q + 3'd1;
  assign accept  = bus.in_valid && !hold_full_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ones_d    = ones_q;
    shift_d   = shift_q;
    last_d    = last_q;
    out_d     = out_q;
    load_byte = 1'b0;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (idx_q == 3'd0 && hold_full_q) begin
          state_d = S_OPEN;
          idx_d   = 3'd0;
          out_d   = FLAG[0];
          ones_d  = 3'd0;
        end else if (FLAG_IDLE) begin
          out_d = FLAG[idx_q];
          idx_d = idx_inc;
        end else begin
          out_d = 1'b1;
        end
      end
      S_OPEN: begin
        if (idx_q != 3'd7) begin
          idx_d = idx_inc;
          out_d = FLAG[idx_inc];
        end else begin
          load_byte = 1'b1;
        end
      end
      S_DATA: begin
        if (ones_q == ONES_MAX) begin
          state_d = S_STUFF;
          out_d   = 1'b0;
          ones_d  = 3'd0;
        end else begin
          advance = 1'b1;
        end
      end
      S_STUFF: advance = 1'b1;
      S_CLOSE, S_ABORT: begin
        if (idx_q != 3'd7) begin
          idx_d = idx_inc;
          out_d = (state_q == S_CLOSE) ? FLAG[idx_inc] : 1'b1;
        end else begin
          // Entering IDLE: the first fill bit goes out immediately.
          state_d = S_IDLE;
          out_d   = FLAG_IDLE ? FLAG[0] : 1'b1;
          idx_d   = FLAG_IDLE ? 3'd1 : 3'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        out_d   = 1'b1;
      end
    endcase

    // idx_q counts payload bits only; a stuffed 0 leaves it on the bit it
    // followed, so resuming from STUFF continues with the pending bit.
    if (advance) begin
      if (idx_q != 3'd7) begin
        state_d = S_DATA;
        idx_d   = idx_inc;
        out_d   = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
        ones_d  = shift_q[0] ? ones_q + 3'd1 : 3'd0;
      end else if (last_q) begin
        state_d = S_CLOSE;
        idx_d   = 3'd0;
        out_d   = FLAG[0];
      end else if (hold_full_q) begin
        load_byte = 1'b1;
      end else begin
        state_d = S_ABORT;
        idx_d   = 3'd0;
        out_d   = 1'b1;
      end
    end

    // The ones count carries across byte boundaries (cleared only on OPEN).
    if (load_byte) begin
      state_d = S_DATA;
      idx_d   = 3'd0;
      out_d   = hold_q[0];
      shift_d = {1'b0, hold_q[7:1]};
      last_d  = hold_last_q;
      ones_d  = hold_q[0] ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      ones_q      <= 3'd0;
      shift_q     <= 8'h00;
      last_q      <= 1'b0;
      out_q       <= 1'b1;
      hold_q      <= 8'h00;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      out_q   <= out_d;
      // accept needs an empty holding reg and load_byte a full one, so the
      // two never coincide.
      if (accept) begin
        hold_q      <= bus.in_data;
        hold_last_q <= bus.in_last;
        hold_full_q <= 1'b1;
      end
      if (load_byte) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready = !hold_full_q;
  assign bus.out      = out_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.underrun = (state_q == S_ABORT) && (idx_q == 3'd0);

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_hdlc_tx_framer
// Directed bench for hdlc_tx_framer. Each frame's expected line stream
// (out, busy, underrun per cycle) is built from the frame bytes by a bit-level
// stuffing model and queued before the bytes are driven; every cycle one entry
// is popped and compared.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hdlc_tx_framer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hdlc_tx_framer_if bus ();

  hdlc_tx_framer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int busy_cnt   = 0;

  logic [7:0] flag_b = 8'h7E;
  logic [7:0] src_data[$];
  logic       src_last[$];
  logic [2:0] exp_q[$];     // {out, busy, underrun}

  task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: out/busy/underrun observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic present();
    if (src_data.size() > 0) begin
      bus.in_valid = 1'b1;
      bus.in_data  = src_data[0];
      bus.in_last  = src_last[0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic add_byte(input logic [7:0] d, input logic l);
    src_data.push_back(d);
    src_last.push_back(l);
  endtask

  task automatic push_const(input int n, input logic [2:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic push_flag(input logic busy_v);
    for (int i = 0; i < 8; i++) exp_q.push_back({flag_b[i], busy_v, 1'b0});
  endtask

  // Opening flag, stuffed payload, then closing flag or abort depending on
  // whether the final queued byte carries in_last.
  task automatic push_frame_exp();
    int   cnt;
    logic v;
    logic [7:0] d;
    cnt = 0;
    push_flag(1'b1);
    foreach (src_data[j]) begin
      d = src_data[j];
      for (int b = 0; b < 8; b++) begin
        v = d[b];
        exp_q.push_back({v, 2'b10});
        cnt = v ? cnt + 1 : 0;
        if (cnt == 5) begin
          exp_q.push_back(3'b010);
          cnt = 0;
        end
      end
    end
    if (src_last[src_last.size() - 1]) begin
      push_flag(1'b1);
    end else begin
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 1'b1, (i == 0)});
    end
  endtask

  // Called at the start of cycle 0 (just after a rising edge). Raises in_valid
  // at the start of cycle present_at, then checks n_check queued entries
  // (all of them if n_check <= 0), feeding the next byte after each handshake.
  task automatic run_frame(input string tag, input int present_at, input int n_check);
    logic [2:0] e;
    logic       fire;
    int         lim;
    busy_cnt = 0;
    lim = (n_check > 0) ? n_check : exp_q.size();
    if (present_at == 0) present();
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check3($sformatf("%s[%0d]", tag, k), {bus.out, bus.busy, bus.underrun}, e);
      if (bus.busy) busy_cnt++;
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        void'(src_data.pop_front());
        void'(src_last.pop_front());
        present();
      end
      if (k + 1 == present_at) present();
    end
    $display("frame %s: %0d line cycles checked, busy %0d cycles", tag, lim, busy_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    reset        = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check3("reset_line", {bus.out, bus.busy, bus.underrun}, 3'b100);
    check_int("reset_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef HDLC_TX_FLAG_IDLE_EN
    // Byte accepted at cycle 3: fill flag on cycles 1..8, own opening flag
    // on 9..16, then payload, closing flag and fill flags again.
    add_byte(8'hFF, 1'b1);
    push_const(1, 3'b100);
    push_flag(1'b0);
    push_frame_exp();
    push_flag(1'b0);
    push_flag(1'b0);
    run_frame("flag_idle", 3, 0);
`else
    // 0x00 single byte: three plain flags/bytes, busy for exactly 24 cycles.
    add_byte(8'h00, 1'b1);
    push_const(2, 3'b100);
    push_frame_exp();
    push_const(3, 3'b100);
    run_frame("byte00", 0, 0);
    check_int("byte00_busy_cycles", busy_cnt, 24);

    // 0xFF: 11111 0 111 between the flags.
    add_byte(8'hFF, 1'b1);
    push_const(2, 3'b100);
    push_frame_exp();
    push_const(3, 3'b100);
    run_frame("byteFF", 0, 0);
    check_int("byteFF_busy_cycles", busy_cnt, 25);

    // Two-byte frame 0x1F, 0x7C.
    add_byte(8'h1F, 1'b0);
    add_byte(8'h7C, 1'b1);
    push_const(2, 3'b100);
    push_frame_exp();
    push_const(3, 3'b100);
    run_frame("1F_7C", 0, 0);

    // Ones run spanning a byte boundary (0xE0 -> 0x03) and a final run of
    // five ones that needs a stuff right before the closing flag (0xF8).
    add_byte(8'hE0, 1'b0);
    add_byte(8'h03, 1'b0);
    add_byte(8'hF8, 1'b1);
    push_const(2, 3'b100);
    push_frame_exp();
    push_const(3, 3'b100);
    run_frame("E0_03_F8", 0, 0);

    // Underrun: 0x12 without in_last, source then goes quiet -> abort.
    add_byte(8'h12, 1'b0);
    push_const(2, 3'b100);
    push_frame_exp();
    push_const(3, 3'b100);
    run_frame("underrun", 0, 0);
    check_int("underrun_busy_cycles", busy_cnt, 24);

    // Reset while the 4th payload bit of a 3-byte frame is on the line.
    add_byte(8'hA5, 1'b0);
    add_byte(8'h3C, 1'b0);
    add_byte(8'h81, 1'b1);
    push_const(2, 3'b100);
    push_frame_exp();
    run_frame("pre_reset", 0, 13);
    reset = 1'b1;
    @(negedge clk);
    check3("reset_mid_4th_bit", {bus.out, bus.busy, bus.underrun}, {1'b0, 2'b10});
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    src_data.delete();
    src_last.delete();
    exp_q.delete();
    @(negedge clk);
    check3("after_reset_line", {bus.out, bus.busy, bus.underrun}, 3'b100);
    check_int("after_reset_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // A fresh frame after the reset must be bit-exact.
    add_byte(8'h5A, 1'b0);
    add_byte(8'hFF, 1'b1);
    push_const(2, 3'b100);
    push_frame_exp();
    push_const(3, 3'b100);
    run_frame("post_reset", 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
